// File: rtl/y86_pkg.sv
// y86_pkg: Y86 memory-stage icodes, FSM state type and op classifiers
package y86_pkg;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_write(input logic [3:0] ic);
    return ic == IRMMOVQ || ic == IPUSHQ || ic == ICALL;
  endfunction
  function automatic logic is_read(input logic [3:0] ic);
    return ic == IMRMOVQ || ic == IPOPQ || ic == IRET;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W storage, synchronous write, combinational read, no reset
module dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_stage.sv
// dmem_stage: Y86 data-memory stage with fixed-latency valid/ready handshake
module dmem_stage
  import y86_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error
);
  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);
  if (LATENCY < 1) begin : g_lat_chk
    $error("dmem_stage: LATENCY must be at least 1");
  end
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        icode_q;
  logic [DATA_W-1:0] addr_q, wdata_q, valm_q;
  logic              err_q;
  logic              accept, enter_done, wr, rd, fault;
  logic [3:0]        cur_icode;
  logic [DATA_W-1:0] cur_addr, cur_wdata, word, rdata;
  assign accept = in_valid && state_q == IDLE;
  // With LATENCY=1 the op completes on the accept edge, so decode straight from the inputs in IDLE
  assign cur_icode = state_q == IDLE ? icode : icode_q;
  assign cur_addr  = state_q == IDLE ? ((icode == IPOPQ || icode == IRET) ? valA : valE) : addr_q;
  assign cur_wdata = state_q == IDLE ? (icode == ICALL ? valP : valA) : wdata_q;
  assign wr    = is_write(cur_icode);
  assign rd    = is_read(cur_icode);
  assign word  = cur_addr >> LSB;
  assign fault = (wr || rd) && ((cur_addr & DATA_W'(NB - 1)) != '0 || word >= DATA_W'(DEPTH));
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d    = LATENCY == 1 ? DONE : BUSY;
        cnt_d      = CW'(LATENCY - 1);
        enter_done = LATENCY == 1;
      end
      BUSY: begin
        cnt_d      = cnt_q - CW'(1);
        enter_done = cnt_q == CW'(1);
        state_d    = enter_done ? DONE : BUSY;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      icode_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valm_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        icode_q <= icode;
        addr_q  <= cur_addr;
        wdata_q <= cur_wdata;
      end
      if (enter_done) begin
        valm_q <= (rd && !fault) ? rdata : '0;
        err_q  <= fault;
      end
    end
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (enter_done && wr && !fault),
    .addr  (word[AW-1:0]),
    .wdata (cur_wdata),
    .rdata (rdata)
  );
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign valM       = valm_q;
  assign dmem_error = err_q;
endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: directed checks of dmem_stage at LATENCY 1..4
module tb_dmem_stage;
  import y86_pkg::*;
  localparam int DEPTH = 256;
  localparam logic [63:0] OOR = 64'(DEPTH * 8);
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  icode = 4'h0;
  logic [63:0] valE = '0, valA = '0, valP = '0;
  logic [3:0]  in_ready, out_valid, err;
  logic [63:0] valm [4];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_stage #(.DATA_W(64), .DEPTH(DEPTH), .LATENCY(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready[g]),
      .icode      (icode),
      .valE       (valE),
      .valA       (valA),
      .valP       (valP),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready),
      .valM       (valm[g]),
      .dmem_error (err[g])
    );
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic op_chk(input string tag, input logic [3:0] ic, input logic [63:0] e, a, p,
                        input logic [63:0] exp_m, input logic exp_err);
    int lat;
    icode = ic; valE = e; valA = a; valP = p; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid[1] && lat < 20);
    chk({tag, "_lat"}, 64'(lat), 64'd2);
    chk({tag, "_valM"}, valm[1], exp_m);
    chk({tag, "_err"}, 64'(err[1]), {63'd0, exp_err});
    @(posedge clk); #1;
  endtask
  initial begin
    int n;
    int first [4];
    logic [63:0] fm [4];
    logic [3:0] fe;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready[1]), 64'd1);
    chk("rst_out_valid", 64'(out_valid[1]), 64'd0);
    chk("rst_valM", valm[1], 64'd0);
    chk("rst_err", 64'(err[1]), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    op_chk("rmmovq", IRMMOVQ, 64'h50, 64'h1234567890ABCDEF, 64'h0, 64'h0, 1'b0);
    op_chk("mrmovq", IMRMOVQ, 64'h50, 64'h0, 64'h0, 64'h1234567890ABCDEF, 1'b0);
    op_chk("call", ICALL, 64'h100, 64'h0, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b0);
    op_chk("ret", IRET, 64'h0, 64'h100, 64'h0, 64'hAAAAAAAAAAAAAAAA, 1'b0);
    op_chk("pushq", IPUSHQ, 64'h18, 64'hCCCCCCCCCCCCCCCC, 64'h0, 64'h0, 1'b0);
    op_chk("popq", IPOPQ, 64'h0, 64'h18, 64'h0, 64'hCCCCCCCCCCCCCCCC, 1'b0);
    op_chk("re_read", IMRMOVQ, 64'h50, 64'h0, 64'h0, 64'h1234567890ABCDEF, 1'b0);
    op_chk("misalign", IMRMOVQ, 64'h51, 64'h0, 64'h0, 64'h0, 1'b1);
    op_chk("oor_read", IMRMOVQ, OOR, 64'h0, 64'h0, 64'h0, 1'b1);
    op_chk("wr_idx0", IRMMOVQ, 64'h0, 64'h0F0F, 64'h0, 64'h0, 1'b0);
    op_chk("oor_write", IRMMOVQ, OOR, 64'hBAD, 64'h0, 64'h0, 1'b1);
    op_chk("idx0_kept", IMRMOVQ, 64'h0, 64'h0, 64'h0, 64'h0F0F, 1'b0);
    icode = IMRMOVQ; valE = 64'h50; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    icode = IRMMOVQ; valA = 64'hDEAD;
    n = 0;
    while (!out_valid[1] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid[1]), 64'd1);
      chk("hold_valM", valm[1], 64'h1234567890ABCDEF);
      chk("hold_err", 64'(err[1]), 64'd0);
      chk("hold_in_ready", 64'(in_ready[1]), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 64'(in_ready[1]), 64'd1);
    op_chk("no_accept", IMRMOVQ, 64'h50, 64'h0, 64'h0, 64'h1234567890ABCDEF, 1'b0);
    op_chk("wr_0x20", IRMMOVQ, 64'h20, 64'h7777, 64'h0, 64'h0, 1'b0);
    op_chk("rd_0x20", IMRMOVQ, 64'h20, 64'h0, 64'h0, 64'h7777, 1'b0);
    icode = IRMMOVQ; valE = 64'h20; valA = 64'h5555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_in_ready", 64'(in_ready[1]), 64'd0);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready[1]), 64'd1);
    chk("abort_out_valid", 64'(out_valid[1]), 64'd0);
    chk("abort_valM", valm[1], 64'd0);
    chk("abort_err", 64'(err[1]), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    op_chk("after_abort", IMRMOVQ, 64'h20, 64'h0, 64'h0, 64'h7777, 1'b0);
    rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    first = '{0, 0, 0, 0};
    fm = '{default: '1};
    fe = '1;
    icode = INOP; valE = 64'h51; valA = 64'h51; in_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++)
        if (out_valid[i] && first[i] == 0) begin
          first[i] = c;
          fm[i] = valm[i];
          fe[i] = err[i];
        end
    end
    chk("lat1", 64'(first[0]), 64'd1);
    chk("lat2", 64'(first[1]), 64'd2);
    chk("lat3", 64'(first[2]), 64'd3);
    chk("lat4", 64'(first[3]), 64'd4);
    chk("nop_valM1", fm[0], 64'd0);
    chk("nop_valM4", fm[3], 64'd0);
    chk("nop_err1", 64'(fe[0]), 64'd0);
    chk("nop_err3", 64'(fe[2]), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
